// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions a raw, bouncing, active-low push button into clean events:
// a debounced level plus one-cycle press / release / long-press pulses.
//
// Parameters
//   DEBOUNCE_CYCLES   : consecutive stable cycles needed to accept an edge
//   LONG_PRESS_CYCLES : cycles of accepted hold before long_press fires
//   REPEAT_CYCLES     : auto-repeat period (only with BTN_AUTOREPEAT_EN)
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   btn_n         in   raw button, active-low, asynchronous to clk
//   level         out  debounced button state, 1 = pressed
//   press         out  one-cycle pulse per accepted press (and per repeat)
//   release_pulse out  one-cycle pulse per accepted release
//                      (`release` is a reserved word in SystemVerilog)
//   long_press    out  one-cycle pulse when the hold reaches LONG_PRESS_CYCLES
//
// Build option
//   BTN_AUTOREPEAT_EN : when defined, press re-pulses every REPEAT_CYCLES
//                       while held after long_press. Undefined by default.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 600000,
  parameter int unsigned LONG_PRESS_CYCLES = 12000000,
  parameter int unsigned REPEAT_CYCLES     = 2400000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  // Parameter sanity: values below 2 break the counter terminal conditions.
  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("button_conditioner: all cycle parameters must be >= 2");
  end

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_PRESS_CYCLES);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned      REP_W    = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic [1:0]        sync_q;
  logic              btn;

  logic [1:0]        state_q,    state_d;
  logic [DB_W-1:0]   db_cnt_q,   db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              level_d;
  logic              press_d;
  logic              release_d;
  logic              long_d;

`ifdef BTN_AUTOREPEAT_EN
  logic [REP_W-1:0]  rep_cnt_q,  rep_cnt_d;
`endif

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_n};
    end
  end

  assign btn = ~sync_q[1];

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      level         <= level_d;
      press         <= press_d;
      release_pulse <= release_d;
      long_press    <= long_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q     <= rep_cnt_d;
`endif
    end
  end

  // Next-state, counter and pulse logic.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rep_cnt_d  = rep_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (btn) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end

      PRESS_WAIT: begin
        if (!btn) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = HELD;
          press_d    = 1'b1;
          level_d    = 1'b1;
          hold_cnt_d = '0;
`ifdef BTN_AUTOREPEAT_EN
          rep_cnt_d  = '0;
`endif
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      HELD: begin
        // Hold timer saturates at HOLD_SAT so long_press fires once per press.
        if (hold_cnt_q == HOLD_LAST) begin
          long_d     = 1'b1;
          hold_cnt_d = HOLD_SAT;
`ifdef BTN_AUTOREPEAT_EN
          rep_cnt_d  = '0;
`endif
        end else if (hold_cnt_q < HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
`ifdef BTN_AUTOREPEAT_EN
        // Repeat timer only runs once the hold timer has saturated.
        else begin
          if (rep_cnt_q == REP_LAST) begin
            press_d   = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
`endif
        if (!btn) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end

      RELEASE_WAIT: begin
        // A bounce back to pressed resumes HELD with timers untouched.
        if (btn) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench: directed scenarios followed by random bouncing input,
// all checked cycle by cycle against a run-length reference model.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int unsigned DB = 8;
  localparam int unsigned LP = 40;
  localparam int unsigned RP = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_n;
  logic level;
  logic press;
  logic release_pulse;
  logic long_press;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP),
    .REPEAT_CYCLES     (RP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_n         (btn_n),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: accepted level flips after DB+1 consecutive disagreeing
  // synchronized samples; hold time is counted only over settled-held cycles.
  bit m_s1, m_s2, m_acc, m_long_done;
  int m_run, m_held_cyc, m_rep;
  bit exp_level, exp_press, exp_release, exp_long;

  int press_q[$];
  int release_q[$];
  int long_q[$];
  int lvl_rise;
  int lvl_high_cycles;
  bit prev_level;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_acc = 1'b0; m_long_done = 1'b0;
    m_run = 0; m_held_cyc = 0; m_rep = 0;
    exp_level = 1'b0; exp_press = 1'b0; exp_release = 1'b0; exp_long = 1'b0;
  endtask

  task automatic model_step();
    bit b;
    bit held;
    if (!rst_n) begin
      model_reset();
      return;
    end
    b    = !m_s2;
    held = m_acc && (m_run == 0);
    exp_press = 1'b0; exp_release = 1'b0; exp_long = 1'b0;
    if (b != m_acc) m_run++;
    else            m_run = 0;
    if (held) begin
      m_held_cyc++;
      if (!m_long_done && m_held_cyc == LP) begin
        exp_long    = 1'b1;
        m_long_done = 1'b1;
        m_rep       = 0;
      end else if (m_long_done) begin
        m_rep++;
        if (m_rep == RP) begin
          m_rep = 0;
`ifdef BTN_AUTOREPEAT_EN
          exp_press = 1'b1;
`endif
        end
      end
    end
    if (m_run == DB + 1) begin
      m_acc     = !m_acc;
      m_run     = 0;
      exp_level = m_acc;
      if (m_acc) begin
        exp_press   = 1'b1;
        m_held_cyc  = 0;
        m_long_done = 1'b0;
      end else begin
        exp_release = 1'b1;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_n;
  endtask

  task automatic clear_obs();
    press_q.delete();
    release_q.delete();
    long_q.delete();
    lvl_rise        = -1000;
    lvl_high_cycles = 0;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, step model at posedge.
  task automatic run_cycle(input logic nb, input logic rn);
    btn_n = nb;
    rst_n = rn;
    #1;
    if (!rn) model_reset();
    @(negedge clk);
    chk("level", level, exp_level);
    chk("press", press, exp_press);
    chk("release", release_pulse, exp_release);
    chk("long_press", long_press, exp_long);
    if (press)         press_q.push_back(cyc);
    if (release_pulse) release_q.push_back(cyc);
    if (long_press)    long_q.push_back(cyc);
    if (level && !prev_level && lvl_rise < 0) lvl_rise = cyc;
    if (level) lvl_high_cycles++;
    prev_level = level;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  initial begin
    int s;
    int r;
    int len;
    logic v;
    rst_n      = 1'b0;
    btn_n      = 1'b1;
    prev_level = 1'b0;
    model_reset();
    clear_obs();
    @(posedge clk);
    #1;

    // Reset state
    repeat (3) run_cycle(1'b1, 1'b0);
    chk("rst_level", level, 0);

    // Held press: latency, long press, optional repeats, then release
    clear_obs();
    s = cyc;
    repeat (75) run_cycle(1'b0, 1'b1);
    chk("a_press_lat", (press_q.size() > 0) ? press_q[0] - s : -1, DB + 3);
    chk("a_level_rise", lvl_rise - s, DB + 3);
    chk("a_long_cnt", long_q.size(), 1);
    chk("a_long_ofs", (long_q.size() > 0 && press_q.size() > 0) ? long_q[0] - press_q[0] : -1, LP);
`ifdef BTN_AUTOREPEAT_EN
    chk("a_press_cnt", press_q.size(), 3);
    chk("a_rep1_ofs", (press_q.size() > 1 && long_q.size() > 0) ? press_q[1] - long_q[0] : -1, RP);
    chk("a_rep2_ofs", (press_q.size() > 2 && long_q.size() > 0) ? press_q[2] - long_q[0] : -1, 2 * RP);
`else
    chk("a_press_cnt", press_q.size(), 1);
`endif
    clear_obs();
    repeat (15) run_cycle(1'b1, 1'b1);
    chk("a_rel_cnt", release_q.size(), 1);
    chk("a_level_low", level, 0);

    // Short glitch is rejected
    clear_obs();
    repeat (5)  run_cycle(1'b0, 1'b1);
    repeat (20) run_cycle(1'b1, 1'b1);
    chk("b_press_cnt", press_q.size(), 0);
    chk("b_level_cycles", lvl_high_cycles, 0);

    // Release bounce while held is absorbed
    clear_obs();
    repeat (20) run_cycle(1'b0, 1'b1);
    repeat (3)  run_cycle(1'b1, 1'b1);
    repeat (20) run_cycle(1'b0, 1'b1);
    chk("c_press_cnt", press_q.size(), 1);
    chk("c_rel_none", release_q.size(), 0);
    repeat (15) run_cycle(1'b1, 1'b1);
    chk("c_rel_cnt", release_q.size(), 1);
    chk("c_level_low", level, 0);

    // Reset while held: no release, fresh press after reset
    clear_obs();
    repeat (20) run_cycle(1'b0, 1'b1);
    chk("d_press_cnt", press_q.size(), 1);
    clear_obs();
    repeat (3) run_cycle(1'b0, 1'b0);
    chk("d_level_rst", level, 0);
    r = cyc;
    repeat (20) run_cycle(1'b0, 1'b1);
    chk("d_rel_none", release_q.size(), 0);
    chk("d_press_lat", (press_q.size() > 0) ? press_q[0] - r : -1, DB + 3);
    repeat (15) run_cycle(1'b1, 1'b1);

    // Random bouncing input with occasional resets
    for (int seg = 0; seg < 60; seg++) begin
      v = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: len = $urandom_range(1, 6);
        5, 6, 7:       len = $urandom_range(8, 20);
        default:       len = $urandom_range(40, 80);
      endcase
      if ($urandom_range(0, 14) == 0) begin
        repeat ($urandom_range(1, 3)) run_cycle(v, 1'b0);
      end
      repeat (len) run_cycle(v, 1'b1);
    end
    repeat (15) run_cycle(1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 600000, meaning consecutive stable clk cycles required to accept a press or release (50 ms at 12 MHz).
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 12000000, meaning clk cycles of accepted hold before long_press fires (1 s).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 2400000, meaning auto-repeat period in clk cycles; used only with BTN_AUTOREPEAT_EN.
REQ-004 SHALL have port clk  input  1  system clock, the only clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port btn_n  input  1  raw button from pmod pin, active-low, asynchronous to clk, bouncing.
REQ-007 SHALL have port level  output  1  debounced button state, 1 = pressed.
REQ-008 SHALL have port press  output  1  one-cycle pulse per accepted press (and per repeat when enabled).
REQ-009 SHALL have port release  output  1  one-cycle pulse per accepted release.
REQ-010 SHALL have port long_press  output  1  one-cycle pulse when hold reaches LONG_PRESS_CYCLES.

Function
REQ-011 SHALL pass btn_n through a two-flop synchronizer; btn = inverted output of second flop; no other logic reads btn_n.
REQ-012 SHALL implement FSM states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-013 IDLE: btn=1 -> PRESS_WAIT, debounce counter cleared to 0; else stay.
REQ-014 PRESS_WAIT: btn=0 -> IDLE (glitch rejected, no output); counter increments per cycle with btn=1; at count DEBOUNCE_CYCLES-1 with btn=1 -> HELD.
REQ-015 Entry to HELD SHALL assert press for exactly one cycle and set level=1 in the same cycle; hold counter cleared.
REQ-016 Latency: btn_n held low from cycle 0 -> press high in cycle DEBOUNCE_CYCLES+3, exactly.
REQ-017 HELD: hold counter increments, saturating at LONG_PRESS_CYCLES; long_press pulses one cycle when it reaches LONG_PRESS_CYCLES-1, at most once per accepted press.
REQ-018 HELD: btn=0 -> RELEASE_WAIT, debounce counter cleared; level remains 1.
REQ-019 RELEASE_WAIT: btn=1 -> HELD, no press pulse, hold counter preserved; at count DEBOUNCE_CYCLES-1 with btn=0 -> IDLE, release pulses one cycle, level=0 same cycle.
REQ-020 press, release, long_press SHALL be registered and mutually exclusive in any cycle except press with long_press when auto-repeat is enabled (REQ-026).
REQ-021 Counters SHALL be sized $clog2 of their maximum parameter plus one bit; no wrap-around is permitted.
REQ-022 Parameters SHALL be >= 2; smaller values are unsupported.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, all counters 0, synchronizer flops to released (1), level=0, press=0, release=0, long_press=0.
REQ-024 Reset asserted mid-operation (any state) SHALL abort without emitting release; after deassertion a still-held button is re-debounced from IDLE and yields a fresh press.
REQ-025 Reset deassertion is synchronized externally; block requires no extra logic for it.

Configuration
REQ-026 With BTN_AUTOREPEAT_EN defined: in HELD after long_press, press re-pulses every REPEAT_CYCLES cycles while in HELD; first repeat at REPEAT_CYCLES cycles after long_press; repeat timer pauses in RELEASE_WAIT and resumes on bounce back to HELD.
REQ-027 Without BTN_AUTOREPEAT_EN: press pulses once per accepted press; REPEAT_CYCLES ignored; no repeat-timer logic synthesized.

Verification (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=40, REPEAT_CYCLES=10)
REQ-028 btn_n low at cycle 0, held -> press high only in cycle 11, level high from cycle 11.
REQ-029 btn_n low for 5 cycles, high for 20 -> no press, level stays 0, state back to IDLE.
REQ-030 Held press, then btn_n high 3 cycles, low again -> no release, no second press; later stable release of 8 cycles -> single release pulse, level 0.
REQ-031 Hold 60 cycles after press -> exactly one long_press, 40 cycles after press; macro defined -> additional press pulses 10 and 20 cycles after long_press; macro undefined -> none.
REQ-032 rst_n pulsed low while HELD, btn_n still low -> all outputs 0 immediately, no release; press recurs 11 cycles after rst_n rises.
